// File: rtl/cla_addsub_pipe.sv
// cla_addsub_pipe: two-stage pipelined add/subtract unit with ready/valid
// handshakes and an internal carry flag for ADC/SBC chaining.
// Stage 1 adds the low half with 4-bit carry-lookahead groups; stage 2 adds
// the high half with the registered low carry and forms the flags.
//
// Ports:
//   sys_clk    in   system clock, rising edge
//   sys_rst    in   synchronous reset, active high
//   in_valid   in   operand beat offered
//   in_ready   out  beat accepted this cycle (combinational)
//   a, b       in   operands, WIDTH bits
//   op         in   0=ADD 1=ADC 2=SUB 3=SBC
//   out_valid  out  result beat offered
//   out_ready  in   consumer accepts result
//   sum        out  result, WIDTH bits
//   co         out  carry (ADD/ADC) or borrow (SUB/SBC)
//   ov         out  signed overflow
//   z          out  sum == 0
//   cflag      out  internal carry flag
module cla_addsub_pipe #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ov,
    output logic             z,
    output logic             cflag
);

    localparam int unsigned H  = WIDTH / 2;
    localparam int unsigned NG = H / 4;

    // 4-bit group carry generator; returns active-low carries c4..c1.
    function automatic logic [3:0] cla4_cn(input logic [3:0] g,
                                           input logic [3:0] p,
                                           input logic       ci);
        logic c1, c2, c3, c4;
        c1 = g[0] | (p[0] & ci);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & ci);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);
        return ~{c4, c3, c2, c1};
    endfunction

    // Half-width adder: nibble groups chained through each group's c4.
    function automatic logic [H:0] cla_add(input logic [H-1:0] x,
                                           input logic [H-1:0] y,
                                           input logic         ci);
        logic [H-1:0] g, p, s;
        logic [3:0]   cn;
        logic         c;
        g = x & y;
        p = x ^ y;
        s = '0;
        c = ci;
        for (int unsigned k = 0; k < NG; k++) begin
            cn         = cla4_cn(g[4*k +: 4], p[4*k +: 4], c);
            s[4*k +: 4] = p[4*k +: 4] ^ {~cn[2:0], c};
            c          = ~cn[3];
        end
        return {c, s};
    endfunction

    // Stage 1 registers
    logic         r_s1_valid;
    logic [H-1:0] r_sum_lo;
    logic         r_c_lo;
    logic [H-1:0] r_a_hi;   // r_a_hi[H-1] is a[MSB]
    logic [H-1:0] r_bb_hi;
    logic         r_sub;

    // Stage 2 / output registers
    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_co;
    logic             r_ov;
    logic             r_z;
    logic             r_cflag;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_in_fire;
    logic [WIDTH-1:0] w_bb;
    logic             w_cin;
    logic [H:0]       w_lo;
    logic [H:0]       w_hi;
    logic [WIDTH-1:0] w_sum;
    logic             w_co;
    logic             w_ov;
    logic             w_z;

    // Handshake and carry interlock: ADC/SBC wait until S1 is empty so
    // cflag already holds the carry of every earlier beat.
    always_comb begin
        w_s2_adv  = ~r_out_valid | out_ready;
        w_s1_adv  = ~r_s1_valid | w_s2_adv;
        in_ready  = w_s1_adv & ~sys_rst & ~(op[0] & r_s1_valid);
        w_in_fire = in_valid & in_ready;
    end

    // Stage 1 datapath: operand conditioning and low-half add.
    // op[1] selects subtract, op[0] selects carry chaining.
    always_comb begin
        w_bb  = b ^ {WIDTH{op[1]}};
        w_cin = op[0] ? (r_cflag ^ op[1]) : op[1];
        w_lo  = cla_add(a[H-1:0], w_bb[H-1:0], w_cin);
    end

    // Stage 2 datapath: high-half add and flag formation.
    always_comb begin
        w_hi  = cla_add(r_a_hi, r_bb_hi, r_c_lo);
        w_sum = {w_hi[H-1:0], r_sum_lo};
        w_co  = w_hi[H] ^ r_sub;
        w_ov  = (r_a_hi[H-1] == r_bb_hi[H-1]) & (w_hi[H-1] != r_a_hi[H-1]);
        w_z   = ~|w_sum;
    end

    // Pipeline registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_s1_valid  <= 1'b0;
            r_sum_lo    <= '0;
            r_c_lo      <= 1'b0;
            r_a_hi      <= '0;
            r_bb_hi     <= '0;
            r_sub       <= 1'b0;
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_co        <= 1'b0;
            r_ov        <= 1'b0;
            r_z         <= 1'b0;
            r_cflag     <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= w_in_fire;
                if (w_in_fire) begin
                    r_sum_lo <= w_lo[H-1:0];
                    r_c_lo   <= w_lo[H];
                    r_a_hi   <= a[WIDTH-1:H];
                    r_bb_hi  <= w_bb[WIDTH-1:H];
                    r_sub    <= op[1];
                end
            end
            if (w_s2_adv) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_sum   <= w_sum;
                    r_co    <= w_co;
                    r_ov    <= w_ov;
                    r_z     <= w_z;
                    r_cflag <= w_co;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign co        = r_co;
    assign ov        = r_ov;
    assign z         = r_z;
    assign cflag     = r_cflag;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Self-checking bench for cla_addsub_pipe: directed cases with literal
// expectations plus a randomized stream checked against an arithmetic model.
module tb_cla_addsub_pipe;

    localparam int unsigned W = 32;
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_ADC = 2'd1;
    localparam logic [1:0] OP_SUB = 2'd2;
    localparam logic [1:0] OP_SBC = 2'd3;

    logic         sys_clk   = 1'b0;
    logic         sys_rst   = 1'b1;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic [1:0]   op        = 2'd0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         co, ov, z, cflag;

    cla_addsub_pipe #(.WIDTH(W)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .op       (op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .co       (co),
        .ov       (ov),
        .z        (z),
        .cflag    (cflag)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         co;
        logic         ov;
        logic         z;
    } res_t;

    res_t exp_q[$];
    res_t cap_q[$];
    logic m_cflag = 1'b0;
    int   n_chk   = 0;
    int   n_fail  = 0;
    bit   rnd_done;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: {c_raw,sum} = a + bb + cin, flags from the arithmetic rules.
    function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic [1:0] mop, input logic cf);
        logic [W-1:0] bb;
        logic         cin;
        logic [W:0]   raw;
        res_t         r;
        bb = (mop == OP_SUB || mop == OP_SBC) ? ~mb : mb;
        case (mop)
            OP_ADD:  cin = 1'b0;
            OP_ADC:  cin = cf;
            OP_SUB:  cin = 1'b1;
            default: cin = ~cf;
        endcase
        raw   = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, cin};
        r.sum = raw[W-1:0];
        r.co  = (mop == OP_SUB || mop == OP_SBC) ? ~raw[W] : raw[W];
        r.ov  = (ma[W-1] == bb[W-1]) && (r.sum[W-1] != ma[W-1]);
        r.z   = (r.sum == '0);
        return r;
    endfunction

    // Compare process: every output cycle against the model queue.
    bit   prev_stall = 1'b0;
    res_t prev;
    always @(negedge sys_clk) begin
        res_t act;
        res_t r;
        if (sys_rst) begin
            chk("in_ready_in_reset", {63'd0, in_ready}, 64'd0);
            exp_q.delete();
            m_cflag    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (out_valid) begin
                act.sum = sum; act.co = co; act.ov = ov; act.z = z;
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL spurious_out: out_valid=1 with no beat pending, sum=0x%0h", sum);
                end else begin
                    chk("out_sum", {32'd0, sum}, {32'd0, exp_q[0].sum});
                    chk("out_co", {63'd0, co}, {63'd0, exp_q[0].co});
                    chk("out_ov", {63'd0, ov}, {63'd0, exp_q[0].ov});
                    chk("out_z", {63'd0, z}, {63'd0, exp_q[0].z});
                    chk("out_cflag", {63'd0, cflag}, {63'd0, exp_q[0].co});
                end
                if (prev_stall)
                    chk("stall_hold", {29'd0, sum, co, ov, z}, {29'd0, prev.sum, prev.co, prev.ov, prev.z});
                if (out_ready) begin
                    cap_q.push_back(act);
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
                prev_stall = !out_ready;
                prev       = act;
            end else begin
                if (prev_stall) chk("stall_hold_valid", {63'd0, out_valid}, 64'd1);
                prev_stall = 1'b0;
            end
            if (in_valid && in_ready) begin
                r       = model(a, b, op, m_cflag);
                m_cflag = r.co;
                exp_q.push_back(r);
                chk("in_flight_le2", {63'd0, exp_q.size() <= 2}, 64'd1);
            end
        end
    end

    // Offer one beat and hold it until accepted.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic [1:0] top, input bit expect_stall);
        bit done;
        done = 1'b0;
        a = ta; b = tb; op = top; in_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge sys_clk);
            if (i == 0 && expect_stall) chk("interlock_in_ready", {63'd0, in_ready}, 64'd0);
            done = in_ready;
            @(posedge sys_clk); #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_chk++; n_fail++;
            $display("FAIL send_timeout: beat a=0x%0h op=%0d not accepted", ta, top);
        end
    endtask

    // Wait until the pipeline and model are empty.
    task automatic drain();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 500 && !idle; i++) begin
            @(posedge sys_clk); #2;
            idle = (exp_q.size() == 0) && !out_valid;
        end
        if (!idle) begin
            n_chk++; n_fail++;
            $display("FAIL drain_timeout: %0d beats still pending", exp_q.size());
        end
    endtask

    task automatic chk_cap(input int idx, input logic [W-1:0] esum,
                           input logic eco, input logic eov, input logic ez);
        if (idx >= cap_q.size()) begin
            n_chk++; n_fail++;
            $display("FAIL cap_missing: result %0d absent, got %0d results", idx, cap_q.size());
        end else begin
            chk("lit_sum", {32'd0, cap_q[idx].sum}, {32'd0, esum});
            chk("lit_flags", {61'd0, cap_q[idx].co, cap_q[idx].ov, cap_q[idx].z},
                {61'd0, eco, eov, ez});
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h0000_FFFF;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_regs", {31'd0, sum, co, ov, z, cflag}, 64'd0);
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;

        // Low-half carry crosses into stage 2; latency check
        cap_q.delete();
        send(32'h0000_FFFF, 32'h0000_0001, OP_ADD, 1'b0);
        @(negedge sys_clk);
        chk("lat_first_edge", {63'd0, out_valid}, 64'd0);
        @(negedge sys_clk);
        chk("lat_second_edge", {63'd0, out_valid}, 64'd1);
        drain();
        chk("t1_count", 64'(cap_q.size()), 64'd1);
        chk_cap(0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);

        // ADD carry out, then ADC chained with interlock stall
        cap_q.delete();
        send(32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, 1'b0);
        send(32'h0, 32'h0, OP_ADC, 1'b1);
        drain();
        chk_cap(0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        chk_cap(1, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        chk("t2_cflag_after", {63'd0, cflag}, 64'd0);

        // SUB borrow then SBC consuming it
        cap_q.delete();
        send(32'h0000_0005, 32'h0000_0007, OP_SUB, 1'b0);
        send(32'h0000_0010, 32'h0000_0001, OP_SBC, 1'b1);
        drain();
        chk_cap(0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
        chk_cap(1, 32'h0000_000E, 1'b0, 1'b0, 1'b0);

        // Signed overflow both directions
        cap_q.delete();
        send(32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, 1'b0);
        send(32'h8000_0000, 32'h0000_0001, OP_SUB, 1'b0);
        drain();
        chk_cap(0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        chk_cap(1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);

        // Stream of 8 ADDs under periodic backpressure
        cap_q.delete();
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(W'(i) * 32'h1111_0000 + W'(i), 32'h0000_FFFF + W'(i), OP_ADD, 1'b0);
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    out_ready = (c % 4 == 0) || (c % 4 == 3);
                    @(posedge sys_clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("stream_count", 64'(cap_q.size()), 64'd8);
        for (int i = 0; i < 8 && i < cap_q.size(); i++)
            chk("stream_order", {32'd0, cap_q[i].sum},
                {32'd0, W'(i) * 32'h1111_0000 + W'(i) + 32'h0000_FFFF + W'(i)});

        // Reset with two beats in flight
        out_ready = 1'b0;
        send(32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, 1'b0);
        send(32'h0000_0001, 32'h0000_0002, OP_ADD, 1'b0);
        @(negedge sys_clk);
        chk("pre_rst_cflag", {63'd0, cflag}, 64'd1);
        @(posedge sys_clk); #1;
        sys_rst = 1'b1;
        @(negedge sys_clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge sys_clk); #1;
        @(negedge sys_clk);
        chk("rst_flush_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_flush_cflag", {63'd0, cflag}, 64'd0);
        @(posedge sys_clk); #1;
        sys_rst   = 1'b0;
        out_ready = 1'b1;
        cap_q.delete();
        repeat (4) @(posedge sys_clk);
        #1;
        chk("rst_no_ghost", 64'(cap_q.size()), 64'd0);
        send(32'h0000_0003, 32'h0000_0004, OP_ADD, 1'b0);
        drain();
        chk("post_rst_count", 64'(cap_q.size()), 64'd1);
        chk_cap(0, 32'h0000_0007, 1'b0, 1'b0, 1'b0);

        // Randomized stream with random backpressure and gaps
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send(pick(), pick(), 2'($urandom_range(0, 3)), 1'b0);
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge sys_clk); #1;
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge sys_clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
